quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter: CNT_W, default 4, width of the position counter output.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: quad_a  input  1  quadrature channel A; asynchronous to clk.
REQ-005 Port: quad_b  input  1  quadrature channel B; asynchronous to clk.
REQ-006 Port: clr  input  1  synchronous counter clear, active-high.
REQ-007 Port: step  output  1  one-cycle pulse per valid quadrature transition.
REQ-008 Port: up_down  output  1  last decoded direction; 1 = up, 0 = down.
REQ-009 Port: counter  output  CNT_W  decoded position count.
REQ-010 Port: err  output  1  one-cycle pulse on an illegal two-bit transition.

Function
REQ-011 The block SHALL pass quad_a and quad_b each through a 2-flop synchronizer before any decode.
REQ-012 The block SHALL define the up sequence of {a,b} as 00->10->11->01->00 and the down sequence as the reverse.
REQ-013 The block SHALL compare each synchronized (or filtered) sample {a,b} against a registered previous sample; 4x decoding, so every legal single-bit change counts.
REQ-014 Legal up transition: step=1 for one cycle, up_down<=1, counter<=counter+1.
REQ-015 Legal down transition: step=1 for one cycle, up_down<=0, counter<=counter-1.
REQ-016 No change: step=0, err=0; counter and up_down hold.
REQ-017 Both bits changing in one sample (00<->11, 10<->01): err=1 for one cycle, step=0, counter and up_down hold, previous sample updated to the new value.
REQ-018 Counter arithmetic SHALL be modulo 2^CNT_W: 2^CNT_W-1 +1 wraps to 0; 0 -1 wraps to 2^CNT_W-1; no saturation, no flag.
REQ-019 clr=1 SHALL load counter to 0 on that edge, overriding any simultaneous increment or decrement; step, up_down and err SHALL still update normally in that cycle.
REQ-020 Latency (filter compiled out): step, err, counter and up_down update on the 3rd rising edge after the edge that first samples an input change (2 sync + 1 decode register).
REQ-021 step and err SHALL never both be 1 in the same cycle.
REQ-022 Inputs changing faster than one transition per sample period are undefined beyond REQ-017; no other recovery is required.

Reset
REQ-023 While rst=0: step=0, err=0, up_down=1, counter=0, synchronizers and previous sample cleared to 00, init flag cleared.
REQ-024 Reset assertion SHALL take effect immediately, independent of clk; deassertion is synchronous in effect (first update on the next rising edge).
REQ-025 The first decoded sample after reset deassertion SHALL only load the previous-sample register and set the init flag; no step and no err for that sample, whatever the input level.
REQ-026 Reset mid-rotation SHALL discard the in-flight transition; counting resumes from 0 relative to the first post-reset sample.

Configuration
REQ-027 Macro QDEC_FILTER_EN: when defined, each synchronized channel SHALL pass through a glitch filter whose output changes only when 3 consecutive synchronized samples agree; this adds 2 cycles to the REQ-020 latency (update on 5th edge).
REQ-028 With QDEC_FILTER_EN defined, a pulse of 1 or 2 clk cycles on either channel SHALL produce no step and no err.
REQ-029 Without QDEC_FILTER_EN, no filter logic exists and single-cycle input pulses are decoded as two transitions.

Verification
REQ-030 Reset with a=b=0, release, then 8 up steps 00->10->11->01->00 spaced 10 cycles -> 8 step pulses, up_down=1, counter=8 (CNT_W=4).
REQ-031 From counter=0, 1 down step -> counter=15, up_down=0; then 1 up step -> counter=0, up_down=1.
REQ-032 {a,b} jumps 00->11 -> exactly one err pulse, no step, counter unchanged; next legal step 11->01 counts up normally.
REQ-033 clr=1 in the same cycle as an up-step decode with counter=5 -> counter=0, step=1, up_down=1.
REQ-034 Release reset with {a,b}=11 held -> no step, no err; next change 11->01 -> counter=1.
REQ-035 QDEC_FILTER_EN defined: 2-cycle glitch on quad_a -> no step/err; a 10-cycle-stable legal step -> step on 5th edge after first sampled change.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder (4x decoding).
// Each channel is synchronized through two flops and may then pass through an
// optional glitch filter, enabled at build time by defining QDEC_FILTER_EN.
// The decoder compares the current {a,b} sample with the previous one.
//   Up sequence:   00 -> 10 -> 11 -> 01 -> 00
//   Down sequence: the reverse of the up sequence.
// A legal single-bit change pulses step and moves the counter by one (modulo).
// A two-bit change pulses err instead, and the counter does not move.
// clr zeroes the counter and takes priority over any count in the same cycle.
module quad_decoder #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clr,
    output logic             step,
    output logic             up_down,
    output logic [CNT_W-1:0] counter,
    output logic             err
);

    // The decoder waits this many cycles after reset before taking its first
    // sample. The wait covers the synchronizer depth, plus the filter
    // history when the filter is built in. This keeps the cleared pipeline
    // value of 00 from being compared against the real input level.
`ifdef QDEC_FILTER_EN
    localparam logic [2:0] FILL_CYC = 3'd4;
`else
    localparam logic [2:0] FILL_CYC = 3'd2;
`endif

    logic             r_a_meta, r_a_sync;
    logic             r_b_meta, r_b_sync;
    logic [2:0]       r_fill_cnt;
    logic             r_init;
    logic [1:0]       r_prev;
    logic             r_step;
    logic             r_err;
    logic             r_up_down;
    logic [CNT_W-1:0] r_counter;

    logic [1:0]       w_cur;
    logic [1:0]       w_delta;
    logic [1:0]       w_next_up;

    // Two-flop synchronizers for the asynchronous encoder channels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_meta <= 1'b0;
            r_a_sync <= 1'b0;
            r_b_meta <= 1'b0;
            r_b_sync <= 1'b0;
        end else begin
            r_a_meta <= quad_a;
            r_a_sync <= r_a_meta;
            r_b_meta <= quad_b;
            r_b_sync <= r_b_meta;
        end
    end

`ifdef QDEC_FILTER_EN
    logic [1:0] r_a_hist, r_b_hist;
    logic       r_a_filt, r_b_filt;
    logic       w_a_filt, w_b_filt;

    // The filter passes the current synchronized value only when it matches
    // the two previous samples. Otherwise it holds its last output.
    assign w_a_filt = (r_a_sync == r_a_hist[0] && r_a_sync == r_a_hist[1]) ? r_a_sync : r_a_filt;
    assign w_b_filt = (r_b_sync == r_b_hist[0] && r_b_sync == r_b_hist[1]) ? r_b_sync : r_b_filt;
    assign w_cur    = {w_a_filt, w_b_filt};

    // Sample history and last stable filter output for each channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_hist <= 2'b00;
            r_b_hist <= 2'b00;
            r_a_filt <= 1'b0;
            r_b_filt <= 1'b0;
        end else begin
            r_a_hist <= {r_a_hist[0], r_a_sync};
            r_b_hist <= {r_b_hist[0], r_b_sync};
            r_a_filt <= w_a_filt;
            r_b_filt <= w_b_filt;
        end
    end
`else
    assign w_cur = {r_a_sync, r_b_sync};
`endif

    // Each legal step changes one bit, and a change of both bits is illegal.
    // The next up state of {a,b} is {~b, a}.
    assign w_delta   = w_cur ^ r_prev;
    assign w_next_up = {~r_prev[0], r_prev[1]};

    // Post-reset down-counter that gates the first decoded sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill_cnt <= FILL_CYC;
        end else if (r_fill_cnt != 3'd0) begin
            r_fill_cnt <= r_fill_cnt - 3'd1;
        end
    end

    // Transition decode, direction and modulo position count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_init    <= 1'b0;
            r_prev    <= 2'b00;
            r_step    <= 1'b0;
            r_err     <= 1'b0;
            r_up_down <= 1'b1;
            r_counter <= '0;
        end else begin
            r_step <= 1'b0;
            r_err  <= 1'b0;
            r_prev <= w_cur;
            if (!r_init) begin
                if (r_fill_cnt == 3'd0) begin
                    r_init <= 1'b1;
                end
            end else if (w_delta == 2'b11) begin
                r_err <= 1'b1;
            end else if (w_delta != 2'b00) begin
                r_step <= 1'b1;
                if (w_cur == w_next_up) begin
                    r_up_down <= 1'b1;
                    r_counter <= r_counter + CNT_W'(1);
                end else begin
                    r_up_down <= 1'b0;
                    r_counter <= r_counter - CNT_W'(1);
                end
            end
            if (clr) begin
                r_counter <= '0;
            end
        end
    end

    assign step    = r_step;
    assign err     = r_err;
    assign up_down = r_up_down;
    assign counter = r_counter;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder. It uses a scoreboard: each stimulus step queues
// the expected step or err event, and a monitor consumes the queue entry when
// the DUT emits the event.
module tb_quad_decoder;

`ifdef QDEC_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       quad_a, quad_b, clr;
    logic       step, up_down, err;
    logic [3:0] counter;

    typedef struct {
        bit         is_err;
        logic       dir;
        logic [3:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    quad_decoder #(.CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .quad_a  (quad_a),
        .quad_b  (quad_b),
        .clr     (clr),
        .step    (step),
        .up_down (up_down),
        .counter (counter),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each step or err pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (step || err) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event: got step=%0b err=%0b dir=%0b cnt=%0d at cyc %0d, expected no event",
                         step, err, up_down, counter, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (step == e.is_err || err != e.is_err || up_down != e.dir ||
                    counter != e.cnt || cyc != e.cyc)
                    $display("FAIL event: got step=%0b err=%0b dir=%0b cnt=%0d cyc=%0d, expected step=%0b err=%0b dir=%0b cnt=%0d cyc=%0d",
                             step, err, up_down, counter, cyc,
                             !e.is_err, e.is_err, e.dir, e.cnt, e.cyc);
                else
                    n_pass++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Change {a,b} at a falling edge and queue the expected decoded event
    task automatic move(input logic a, input logic b, input bit is_err,
                        input logic dir, input logic [3:0] cnt);
        @(negedge clk);
        quad_a = a;
        quad_b = b;
        sb.push_back('{is_err, dir, cnt, cyc + LAT});
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; quad_a = 1'b0; quad_b = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {step, err, up_down, counter}, {1'b0, 1'b0, 1'b1, 4'd0});
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Eight up steps
        move(1, 0, 0, 1, 4'd1);
        move(1, 1, 0, 1, 4'd2);
        move(0, 1, 0, 1, 4'd3);
        move(0, 0, 0, 1, 4'd4);
        move(1, 0, 0, 1, 4'd5);
        move(1, 1, 0, 1, 4'd6);
        move(0, 1, 0, 1, 4'd7);
        move(0, 0, 0, 1, 4'd8);
        check("count_8_up", counter, 8);

        // clr alone zeroes the counter and leaves the direction unchanged
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        check("clr_idle", {up_down, counter}, {1'b1, 4'd0});

        // Down from 0 wraps to 15, then up wraps back to 0
        move(0, 1, 0, 0, 4'd15);
        move(0, 0, 0, 1, 4'd0);

        // Illegal jump 00->11 holds the count, then a legal step counts up
        move(1, 1, 1, 1, 4'd0);
        move(0, 1, 0, 1, 4'd1);

        // Down, down (wrap to 15), then up (wrap to 0)
        move(1, 1, 0, 0, 4'd0);
        move(1, 0, 0, 0, 4'd15);
        move(1, 1, 0, 1, 4'd0);

        // Count up to 5
        move(0, 1, 0, 1, 4'd1);
        move(0, 0, 0, 1, 4'd2);
        move(1, 0, 0, 1, 4'd3);
        move(1, 1, 0, 1, 4'd4);
        move(0, 1, 0, 1, 4'd5);

        // Assert clr on the decode edge of an up step: step still pulses, count reads 0
        begin
            int k;
            @(negedge clk);
            quad_a = 1'b0; quad_b = 1'b0;
            k = cyc;
            sb.push_back('{0, 1'b1, 4'd0, k + LAT});
            repeat (LAT - 1) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            repeat (10) @(negedge clk);
        end

        // Illegal 10->01 holds the count, then 01->00 counts up
        move(1, 0, 0, 1, 4'd1);
        move(0, 1, 1, 1, 4'd1);
        move(0, 0, 0, 1, 4'd2);

        // Short pulse on channel A
        begin
            int k;
            @(negedge clk);
            quad_a = 1'b1;
            k = cyc;
`ifdef QDEC_FILTER_EN
            // A 2-cycle glitch must produce no step and no err
            repeat (2) @(negedge clk);
            quad_a = 1'b0;
            repeat (12) @(negedge clk);
            check("glitch_hold", {up_down, counter}, {1'b1, 4'd2});
`else
            // A 1-cycle pulse decodes as an up step followed by a down step
            sb.push_back('{0, 1'b1, 4'd3, k + LAT});
            sb.push_back('{0, 1'b0, 4'd2, k + 1 + LAT});
            @(negedge clk);
            quad_a = 1'b0;
            repeat (12) @(negedge clk);
`endif
        end

        // Reset mid-rotation: the change in flight is discarded, and reset acts without a clock edge
        @(negedge clk);
        quad_a = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset", {step, err, up_down, counter}, {1'b0, 1'b0, 1'b1, 4'd0});
        quad_b = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("release_at_11", {up_down, counter}, {1'b1, 4'd0});
        move(0, 1, 0, 1, 4'd1);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
